// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared response and FSM state types for the AXI4-Lite register slave
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4lite_reg_file.sv
// rtl/axi4lite_reg_file.sv - register array with byte-enable write port and combinational read port
module axi4lite_reg_file
  import axi4lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    IDX_W       = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Callers mask out-of-range indices, so no bounds guard here.
  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axi4lite_slave_regs.sv
// rtl/axi4lite_slave_regs.sv - AXI4-Lite slave fronting NUM_REGS registers; independent read/write FSMs
// Define AXIL_SLV_WSTRB_EN to honour W_STRB byte lanes; otherwise every in-range write is full-word.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    A_CLK,
  input  logic                    A_RSTn,
  input  logic                    AW_VALID,
  output logic                    AW_READY,
  input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic                    W_VALID,
  output logic                    W_READY,
  input  logic [DATA_WIDTH-1:0]   W_DATA,
  input  logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    B_VALID,
  input  logic                    B_READY,
  output logic [1:0]              B_RESP,
  input  logic                    AR_VALID,
  output logic                    AR_READY,
  input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
  output logic                    R_VALID,
  input  logic                    R_READY,
  output logic [DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]              R_RESP
);

  localparam int LSB    = $clog2(DATA_WIDTH/8);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, wr_go, wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data, rf_rd_data;
  logic [STRB_W-1:0]     wr_strb;

  assign aw_hs = AW_VALID & AW_READY;
  assign w_hs  = W_VALID & W_READY;

  // Commit uses whichever of address/data is still on the bus this cycle, else the held copy.
  assign wr_addr     = aw_held ? aw_addr_q : AW_ADDR;
  assign wr_data     = w_held ? w_data_q : W_DATA;
  assign wr_word     = wr_addr >> LSB;
  assign rd_word     = AR_ADDR >> LSB;
  assign wr_in_range = wr_word < ADDR_WIDTH'(NUM_REGS);
  assign rd_in_range = rd_word < ADDR_WIDTH'(NUM_REGS);
  assign wr_go       = (wr_state == W_IDLE) && (aw_hs || aw_held) && (w_hs || w_held);

`ifdef AXIL_SLV_WSTRB_EN
  assign wr_strb = w_held ? w_strb_q : W_STRB;
`else
  assign wr_strb = '1;
  logic unused_strb;
  assign unused_strb = ^{W_STRB, w_strb_q};
`endif

  axi4lite_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .RESET_VALUE(RESET_VALUE)
  ) u_reg_file (
    .clk    (A_CLK),
    .rst_n  (A_RSTn),
    .wr_en  (wr_go && wr_in_range),
    .wr_idx (wr_word[IDX_W-1:0]),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_idx (rd_word[IDX_W-1:0]),
    .rd_data(rf_rd_data)
  );

  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      AW_READY  <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b0;
      B_RESP    <= OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= AW_ADDR;
            aw_held   <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= W_DATA;
            w_strb_q <= W_STRB;
            w_held   <= 1'b1;
          end
          if (wr_go) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            AW_READY <= 1'b0;
            W_READY  <= 1'b0;
            B_VALID  <= 1'b1;
            B_RESP   <= wr_in_range ? OKAY : SLVERR;
            wr_state <= W_RESP;
          end else begin
            AW_READY <= !(aw_held || aw_hs);
            W_READY  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (B_READY) begin
            B_VALID  <= 1'b0;
            AW_READY <= 1'b1;
            W_READY  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // The port named R_DATA hides the package literal, so read states are package-qualified.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      rd_state <= axi4lite_pkg::R_IDLE;
      AR_READY <= 1'b0;
      R_VALID  <= 1'b0;
      R_DATA   <= '0;
      R_RESP   <= OKAY;
    end else begin
      case (rd_state)
        axi4lite_pkg::R_IDLE: begin
          if (AR_VALID && AR_READY) begin
            R_DATA   <= rd_in_range ? rf_rd_data : '0;
            R_RESP   <= rd_in_range ? OKAY : SLVERR;
            R_VALID  <= 1'b1;
            AR_READY <= 1'b0;
            rd_state <= axi4lite_pkg::R_DATA;
          end else begin
            AR_READY <= 1'b1;
          end
        end
        axi4lite_pkg::R_DATA: begin
          if (R_READY) begin
            R_VALID  <= 1'b0;
            AR_READY <= 1'b1;
            rd_state <= axi4lite_pkg::R_IDLE;
          end
        end
        default: rd_state <= axi4lite_pkg::R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb/tb_axi4lite_slave_regs.sv - randomized self-checking bench against a word-array reference model
module tb_axi4lite_slave_regs;

  localparam int NREGS = 16;

  logic        A_CLK = 1'b0;
  logic        A_RSTn = 1'b0;
  logic        AW_VALID = 1'b0, AW_READY;
  logic [31:0] AW_ADDR = '0;
  logic        W_VALID = 1'b0, W_READY;
  logic [31:0] W_DATA = '0;
  logic [3:0]  W_STRB = '0;
  logic        B_VALID, B_READY = 1'b0;
  logic [1:0]  B_RESP;
  logic        AR_VALID = 1'b0, AR_READY;
  logic [31:0] AR_ADDR = '0;
  logic        R_VALID, R_READY = 1'b0;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [NREGS];

  always #5 A_CLK = ~A_CLK;

  axi4lite_slave_regs dut (
    .A_CLK(A_CLK), .A_RSTn(A_RSTn),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] idx;
    logic [3:0]  eff;
    idx = addr >> 2;
    eff = strb;
`ifndef AXIL_SLV_WSTRB_EN
    eff = 4'hF;
`endif
    if (idx >= NREGS) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (eff[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    return 2'b00;
  endfunction

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] exp_resp;
    fork
      begin
        int n;
        for (int k = 0; k < aw_dly; k++) begin @(negedge A_CLK); check("b_early", B_VALID, 0); end
        AW_VALID = 1'b1; AW_ADDR = addr; n = 0;
        while (!AW_READY && n < 50) begin @(negedge A_CLK); n++; end
        check("aw_ready", AW_READY, 1);
        @(negedge A_CLK);
        AW_VALID = 1'b0; AW_ADDR = $urandom;
      end
      begin
        int n;
        for (int k = 0; k < w_dly; k++) begin @(negedge A_CLK); check("b_early", B_VALID, 0); end
        W_VALID = 1'b1; W_DATA = data; W_STRB = strb; n = 0;
        while (!W_READY && n < 50) begin @(negedge A_CLK); n++; end
        check("w_ready", W_READY, 1);
        @(negedge A_CLK);
        W_VALID = 1'b0; W_DATA = $urandom; W_STRB = 4'($urandom);
      end
    join
    exp_resp = model_write(addr, data, strb);
    check("b_valid_lat", B_VALID, 1);
    check("b_resp", B_RESP, exp_resp);
    check("aw_ready_busy", AW_READY, 0);
    check("w_ready_busy", W_READY, 0);
    for (int k = 0; k < b_dly; k++) begin
      @(negedge A_CLK);
      check("b_valid_hold", B_VALID, 1);
      check("b_resp_hold", B_RESP, exp_resp);
      check("aw_w_ready_hold", {AW_READY, W_READY}, 2'b00);
    end
    B_READY = 1'b1;
    @(negedge A_CLK);
    B_READY = 1'b0;
    check("b_single", B_VALID, 0);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int r_dly);
    logic [31:0] idx, exp_d;
    logic [1:0]  exp_r;
    int n;
    idx = addr >> 2;
    if (idx < NREGS) begin exp_d = model[idx]; exp_r = 2'b00; end
    else begin exp_d = '0; exp_r = 2'b10; end
    AR_VALID = 1'b1; AR_ADDR = addr; n = 0;
    while (!AR_READY && n < 50) begin @(negedge A_CLK); n++; end
    check("ar_ready", AR_READY, 1);
    @(negedge A_CLK);
    AR_VALID = 1'b0; AR_ADDR = $urandom;
    check("r_valid_lat", R_VALID, 1);
    check("r_data", R_DATA, exp_d);
    check("r_resp", R_RESP, exp_r);
    check("ar_ready_busy", AR_READY, 0);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge A_CLK);
      check("r_valid_hold", R_VALID, 1);
      check("r_data_hold", R_DATA, exp_d);
    end
    R_READY = 1'b1;
    @(negedge A_CLK);
    R_READY = 1'b0;
    check("r_single", R_VALID, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    idx = $urandom_range(0, NREGS + 3);
    return (idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, ra;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    repeat (3) @(negedge A_CLK);
    check("rst_ready", {AW_READY, W_READY, AR_READY}, 3'b000);
    check("rst_valid", {B_VALID, R_VALID}, 2'b00);
    check("rst_resp", {B_RESP, R_RESP}, 4'b0000);
    check("rst_rdata", R_DATA, 0);
    A_RSTn = 1'b1;
    @(negedge A_CLK);
    check("idle_ready", {AW_READY, W_READY, AR_READY}, 3'b111);
    for (int i = 0; i < NREGS; i++) read_txn(32'(i * 4), 0);

    write_txn(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    read_txn(32'h08, 0);
    write_txn(32'h04, 32'h12345678, 4'hF, 2, 0, 0);
    read_txn(32'h04, 1);
    write_txn(32'h40, 32'hCAFEF00D, 4'hF, 0, 1, 0);
    read_txn(32'h40, 0);
    for (int i = 0; i < NREGS; i++) read_txn(32'(i * 4), 0);
    write_txn(32'h10, 32'h5555AAAA, 4'hF, 0, 0, 5);
    read_txn(32'h10, 0);

    write_txn(32'h0C, 32'h11111111, 4'hF, 0, 0, 0);
    fork
      write_txn(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      read_txn(32'h0C, 0);
    join
    read_txn(32'h0C, 0);

    write_txn(32'h14, 32'h11223344, 4'hF, 0, 0, 0);
    write_txn(32'h14, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
    read_txn(32'h14, 0);
    write_txn(32'h14, 32'h99999999, 4'b0000, 0, 0, 0);
    read_txn(32'h14, 0);
    write_txn(32'h1B, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    read_txn(32'h18, 0);
    write_txn(32'hFFFF_FFF0, 32'h77777777, 4'hF, 0, 0, 0);
    read_txn(32'hFFFF_FFF0, 0);

    for (int it = 0; it < 60; it++) begin
      a = rand_addr(); d = $urandom; ra = rand_addr();
      case ($urandom_range(0, 2))
        0: write_txn(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: read_txn(a, $urandom_range(0, 3));
        default: fork
          write_txn(a, d, 4'($urandom), 0, 0, $urandom_range(0, 2));
          read_txn(ra, $urandom_range(0, 2));
        join
      endcase
    end

    write_txn(32'h08, 32'h13579BDF, 4'hF, 0, 0, 0);
    AR_VALID = 1'b1; AR_ADDR = 32'h08;
    @(negedge A_CLK);
    AR_VALID = 1'b0;
    check("pre_rst_rvalid", R_VALID, 1);
    #2 A_RSTn = 1'b0;
    #1;
    check("async_rst_rvalid", R_VALID, 0);
    check("async_rst_rdata", R_DATA, 0);
    @(negedge A_CLK);
    A_RSTn = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    @(negedge A_CLK);
    check("post_rst_no_resp", {R_VALID, B_VALID}, 2'b00);
    for (int i = 0; i < NREGS; i++) read_txn(32'(i * 4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
